// File: rtl/lca_seq_add16.sv
// Serial nibble adder: one 4-bit carry-lookahead slice computes sum = a + b + c_in, one nibble per cycle.
// Latency: out_valid rises NIB cycles after the accepting edge; one operation in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the result is taken.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a_in, b_in, c_in sampled at the accepting edge only)
//   out_valid / out_ready result handshake (sum, co[, ovf] stable while out_valid=1)
//   sum, co              registered W-bit sum and carry-out of bit W-1
//   ovf                  registered signed overflow, present only when SEQ_ADD_OVF_EN is defined
//
// Build option: define SEQ_ADD_OVF_EN to add the ovf port and its logic.
module lca_seq_add16 #(
   parameter int NIB = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NIB-1:0]  a_in,
   input  logic [4*NIB-1:0]  b_in,
   input  logic              c_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NIB-1:0]  sum,
   output logic              co
`ifdef SEQ_ADD_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int W = 4 * NIB;
   localparam logic [3:0] LAST = 4'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [W-1:0]  a_r, b_r;
   logic          carry_r;
   logic [3:0]    idx;

   // slice signals
   logic [5:0]    sh;
   logic [3:0]    a_nib, b_nib, p, g, s_nib;
   logic [4:0]    cv;      // cv[i] = carry into bit i of the slice, cv[4] = slice carry-out
   logic [W-1:0]  nib_mask;
   logic          last_nib;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last_nib  = (idx == LAST);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = CALC;
         CALC:    if (last_nib)  state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // carry-lookahead slice on the nibble selected by idx
   always_comb begin
      sh       = {idx, 2'b00};
      a_nib    = 4'(a_r >> sh);
      b_nib    = 4'(b_r >> sh);
      p        = a_nib ^ b_nib;
      g        = a_nib & b_nib;
      cv       = '0;
      cv[0]    = carry_r;
      for (int i = 0; i < 4; i++) begin
         cv[i+1] = g[i] | (p[i] & cv[i]);
      end
      s_nib    = p ^ cv[3:0];
      nib_mask = W'(4'hF) << sh;
   end

   // datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         co      <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= a_in;
                  b_r     <= b_in;
                  carry_r <= c_in;
                  idx     <= '0;
               end
            end
            CALC: begin
               sum     <= (sum & ~nib_mask) | (W'(s_nib) << sh);
               carry_r <= cv[4];
               idx     <= idx + 4'd1;
               if (last_nib) begin
                  co  <= cv[4];
`ifdef SEQ_ADD_OVF_EN
                  // signed overflow: carry into the MSB differs from carry out of it
                  ovf <= cv[3] ^ cv[4];
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lca_seq_add16.sv
// Scoreboard bench for lca_seq_add16: directed operands, expected results queued at issue.
// Monitor pops and compares on every output handshake; stimulus thread checks timing and hold.
// Covers latency, backpressure hold, ignored in_valid while busy, operand changes, mid-op reset.
module tb_lca_seq_add16;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a_in, b_in;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          co;
`ifdef SEQ_ADD_OVF_EN
   logic          ovf;
`endif

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   lca_seq_add16 #(.NIB(NIB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co)
`ifdef SEQ_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: compare on each result handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard, expected none", sum);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("sum", 32'(sum), 32'(e.s));
            check("co",  32'(co),  32'(e.c));
`ifdef SEQ_ADD_OVF_EN
            check("ovf", 32'(ovf), 32'(e.v));
`endif
         end
      end
   end

   // One operation. Caller is positioned 1 time unit after a rising edge with the DUT idle.
   // hold: cycles of out_ready=0 after out_valid; junk: keep in_valid high with other operands while busy.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic ev,
                        input int hold, input logic junk);
      int            n;
      logic [W-1:0]  s0;
      logic          c0;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      a_in      = a;
      b_in      = b;
      c_in      = c;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      q.push_back('{s: es, c: ec, v: ev});
      @(posedge clk); #1;
      // operands change after the accepting edge; result must not follow them
      a_in     = ~a;
      b_in     = ~b;
      c_in     = ~c;
      in_valid = junk;
      n = 0;
      while (!out_valid && n < 20) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(NIB));
      if (hold > 0) begin
         s0 = sum;
         c0 = co;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_sum",       32'(sum),       32'(s0));
            check("hold_co",        32'(co),        32'(c0));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      c_in      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum",       32'(sum),       32'd0);
      check("rst_co",        32'(co),        32'd0);
`ifdef SEQ_ADD_OVF_EN
      check("rst_ovf",       32'(ovf),       32'd0);
`endif

      //     a         b         c     sum       co    ovf   hold junk
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b0);
      do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0,  1'b0);
      do_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 0,  1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 10, 1'b1);
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 3,  1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0,  1'b0);
      do_op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 2,  1'b1);

      // reset two cycles into a calculation; nothing is queued for the aborted op
      a_in      = 16'h9999;
      b_in      = 16'h9999;
      c_in      = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
      check("abort_in_ready",  32'(in_ready),  32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_sum",       32'(sum),       32'd0);
      check("abort_co",        32'(co),        32'd0);
      do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);

      @(posedge clk); #1;
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
